// File: rtl/data_mem_responder_if.sv
// Core-side data memory port: byte address, lane-aligned store data,
// byte enables and the registered read word.
interface data_mem_responder_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  we;
   logic [31:0] rdata;

   modport master (output addr, output wdata, output we, input rdata);
   modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: word RAM with byte-lane writes and a 16-byte MMIO
// window (GPIO, 64-bit cycle counter with coherent high snapshot, status).
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
   input  logic                 clk,
   input  logic                 rst,
   data_mem_responder_if.slave  bus,
   output logic [31:0]          gpio_out,
   output logic                 err
);

   localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

   typedef enum logic [1:0] {
      OFF_GPIO     = 2'd0,
      OFF_CYCLE_LO = 2'd1,
      OFF_CYCLE_HI = 2'd2,
      OFF_STATUS   = 2'd3
   } mmio_off_e;

   logic [31:0]      mem [DEPTH_WORDS];
   logic [63:0]      cycle_cnt;
   logic [31:0]      hi_snap;
   logic             in_ram;
   logic             in_mmio;
   logic             any_we;
   logic             err_set;
   logic             err_clr;
   mmio_off_e        off;
   logic [IDX_W-1:0] idx;
   logic [31:0]      rd_word;

   assign in_ram  = {1'b0, bus.addr} < RAM_BYTES;
   assign in_mmio = bus.addr[31:4] == MMIO_BASE[31:4];
   assign off     = mmio_off_e'(bus.addr[3:2]);
   assign idx     = bus.addr[IDX_W+1:2];
   assign any_we  = |bus.we;

   always_comb begin
      rd_word = '0;
      if (in_ram) begin
         rd_word = mem[idx];
      end else if (in_mmio) begin
         case (off)
            OFF_GPIO:     rd_word = gpio_out;
            OFF_CYCLE_LO: rd_word = cycle_cnt[31:0];
            OFF_CYCLE_HI: rd_word = hi_snap;
            OFF_STATUS:   rd_word = {31'b0, err};
            default:      rd_word = '0;
         endcase
      end
   end

   // Stores to read-only registers and to unmapped space are dropped and flagged.
   always_comb begin
      err_set = 1'b0;
      err_clr = 1'b0;
      if (any_we) begin
         if (in_mmio && (off == OFF_CYCLE_LO || off == OFF_CYCLE_HI)) begin
            err_set = 1'b1;
         end else if (!in_ram && !in_mmio) begin
            err_set = 1'b1;
         end
      end
      if (in_mmio && off == OFF_STATUS && bus.we[0] && bus.wdata[0]) begin
         err_clr = 1'b1;
      end
   end

   // RAM has no reset; an in-flight store may complete even as rst rises.
   always_ff @(posedge clk) begin
      if (in_ram) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (bus.we[i]) begin
               mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rdata <= '0;
         gpio_out  <= '0;
         err       <= 1'b0;
         cycle_cnt <= '0;
         hi_snap   <= '0;
      end else begin
         bus.rdata <= rd_word;
         cycle_cnt <= cycle_cnt + 64'd1;
         if (in_mmio && off == OFF_CYCLE_LO) begin
            hi_snap <= cycle_cnt[63:32];
         end
         if (in_mmio && off == OFF_GPIO) begin
            for (int unsigned i = 0; i < 4; i++) begin
               if (bus.we[i]) begin
                  gpio_out[8*i +: 8] <= bus.wdata[8*i +: 8];
               end
            end
         end
         if (err_set) begin
            err <= 1'b1;
         end else if (err_clr) begin
            err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random
// traffic compared against a behavioural memory-map model.
module tb_data_mem_responder;

   localparam int unsigned DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'hFFFF_FF00;
   localparam logic [31:0] A_GPIO = BASE;
   localparam logic [31:0] A_LO   = BASE + 32'd4;
   localparam logic [31:0] A_HI   = BASE + 32'd8;
   localparam logic [31:0] A_ST   = BASE + 32'd12;
   localparam logic [31:0] A_BAD  = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] gpio_out;
   logic        err;

   data_mem_responder_if bus();

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .gpio_out (gpio_out),
      .err      (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0]     m_mem [int unsigned];
   logic [31:0]     m_gpio;
   logic [31:0]     m_hi;
   logic            m_err;
   longint unsigned m_cnt;
   logic [31:0]     exp_rdata;

   function automatic void model_reset();
      m_gpio = '0;
      m_hi   = '0;
      m_err  = 1'b0;
      m_cnt  = 0;
   endfunction

   // One clock edge of the memory map, described by address ranges.
   function automatic void model_step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] w);
      bit          ram;
      bit          mmio;
      bit          wr;
      int unsigned off;
      int unsigned key;
      logic [31:0] word;
      ram  = (a < DEPTH * 4);
      mmio = (a >= BASE) && (a <= BASE + 32'd15);
      wr   = (w != 4'b0000);
      off  = (a - BASE) / 4;
      key  = a / 4;
      exp_rdata = '0;
      if (ram) begin
         exp_rdata = m_mem.exists(key) ? m_mem[key] : 'x;
      end else if (mmio) begin
         case (off)
            0: exp_rdata = m_gpio;
            1: exp_rdata = m_cnt[31:0];
            2: exp_rdata = m_hi;
            default: exp_rdata = {31'b0, m_err};
         endcase
      end
      if (mmio && off == 1) m_hi = 32'(m_cnt >> 32);
      if (ram && wr) begin
         word = m_mem.exists(key) ? m_mem[key] : '0;
         for (int i = 0; i < 4; i++) if (w[i]) word[8*i +: 8] = wd[8*i +: 8];
         m_mem[key] = word;
      end
      if (mmio && off == 0) begin
         for (int i = 0; i < 4; i++) if (w[i]) m_gpio[8*i +: 8] = wd[8*i +: 8];
      end
      if (wr && ((mmio && (off == 1 || off == 2)) || (!ram && !mmio))) m_err = 1'b1;
      else if (mmio && off == 3 && w[0] && wd[0]) m_err = 1'b0;
      m_cnt = m_cnt + 1;
   endfunction

   task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] w);
      bus.addr  = a;
      bus.wdata = wd;
      bus.we    = w;
      @(posedge clk);
      #1;
      model_step(a, wd, w);
   endtask

   task automatic test_reset();
      bus.addr = '0; bus.wdata = '0; bus.we = '0;
      #1 rst = 1'b1;
      #1;
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", bus.rdata, 32'h0); end
      checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL reset_gpio got=%h exp=%h", gpio_out, 32'h0); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      cycle(A_LO, '0, 4'h0);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL first_cycle_lo got=%h exp=%h", bus.rdata, 32'h0); end
      cycle(A_HI, '0, 4'h0);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL first_cycle_hi got=%h exp=%h", bus.rdata, 32'h0); end
   endtask

   task automatic test_byte_write();
      cycle(32'h10, 32'hAABB_CCDD, 4'hF);
      cycle(32'h10, 32'h1122_3344, 4'b0101);
      cycle(32'h10, '0, 4'h0);
      checks++; if (bus.rdata !== 32'hAA22_CC44) begin errors++; $display("FAIL byte_write got=%h exp=%h", bus.rdata, 32'hAA22_CC44); end
   endtask

   task automatic test_read_first();
      cycle(32'h20, 32'h9, 4'hF);
      cycle(32'h20, 32'h5, 4'hF);
      checks++; if (bus.rdata !== 32'h9) begin errors++; $display("FAIL read_first_old got=%h exp=%h", bus.rdata, 32'h9); end
      cycle(32'h20, '0, 4'h0);
      checks++; if (bus.rdata !== 32'h5) begin errors++; $display("FAIL read_first_new got=%h exp=%h", bus.rdata, 32'h5); end
   endtask

   task automatic test_gpio();
      cycle(A_GPIO, 32'h0000_00FF, 4'hF);
      checks++; if (gpio_out !== 32'hFF) begin errors++; $display("FAIL gpio_write got=%h exp=%h", gpio_out, 32'hFF); end
      cycle(A_GPIO, 32'h1234_5600, 4'b0100);
      checks++; if (gpio_out !== 32'h0034_00FF) begin errors++; $display("FAIL gpio_lane got=%h exp=%h", gpio_out, 32'h0034_00FF); end
      cycle(A_GPIO, 32'hFFFF_FFFF, 4'h0);
      checks++; if (bus.rdata !== 32'h0034_00FF) begin errors++; $display("FAIL gpio_read got=%h exp=%h", bus.rdata, 32'h0034_00FF); end
   endtask

   task automatic test_counter();
      force dut.cycle_cnt = 64'h0000_0001_FFFF_FFFF;
      #1 release dut.cycle_cnt;
      m_cnt = 64'h0000_0001_FFFF_FFFF;
      cycle(A_LO, '0, 4'h0);
      checks++; if (bus.rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL coherent_lo got=%h exp=%h", bus.rdata, 32'hFFFF_FFFF); end
      cycle(A_HI, '0, 4'h0);
      checks++; if (bus.rdata !== 32'h1) begin errors++; $display("FAIL coherent_hi got=%h exp=%h", bus.rdata, 32'h1); end
      cycle(A_LO, '0, 4'h0);
      checks++; if (bus.rdata !== exp_rdata) begin errors++; $display("FAIL advanced_lo got=%h exp=%h", bus.rdata, exp_rdata); end
      force dut.cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
      #1 release dut.cycle_cnt;
      m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
      cycle(A_LO, '0, 4'h0);
      checks++; if (bus.rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pre got=%h exp=%h", bus.rdata, 32'hFFFF_FFFF); end
      cycle(A_LO, '0, 4'h0);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL wrap_lo got=%h exp=%h", bus.rdata, 32'h0); end
      cycle(A_HI, '0, 4'h0);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL wrap_hi got=%h exp=%h", bus.rdata, 32'h0); end
   endtask

   task automatic test_error();
      cycle(A_BAD, 32'hDEAD_BEEF, 4'h1);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL unmapped_write_err got=%b exp=1", err); end
      cycle(A_BAD, '0, 4'h0);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read got=%h exp=%h", bus.rdata, 32'h0); end
      cycle(A_ST, '0, 4'h0);
      checks++; if (bus.rdata !== 32'h1) begin errors++; $display("FAIL status_read got=%h exp=%h", bus.rdata, 32'h1); end
      cycle(A_ST, 32'h1, 4'h1);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL status_clear got=%b exp=0", err); end
      cycle(A_BAD, '0, 4'h0);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL unmapped_read_no_err got=%b exp=0", err); end
      cycle(A_LO, 32'h5, 4'h2);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL ro_write_err got=%b exp=1", err); end
      cycle(A_ST, 32'h1, 4'h2);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL clear_needs_we0 got=%b exp=1", err); end
      cycle(A_ST, 32'h0, 4'h1);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL clear_needs_bit0 got=%b exp=1", err); end
      cycle(A_ST, 32'h1, 4'hF);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL status_clear2 got=%b exp=0", err); end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  w;
      int unsigned sel;
      for (int i = 0; i < 64; i++) cycle(32'(i * 4), $urandom, 4'hF);
      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 5) a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
         else if (sel <= 8) a = BASE + 32'($urandom_range(0, 15));
         else begin
            case ($urandom_range(0, 2))
               0: a = 32'(DEPTH * 4 + $urandom_range(0, 4095));
               1: a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
               default: a = BASE - 32'd4;
            endcase
         end
         wd = $urandom;
         w  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         cycle(a, wd, w);
         checks++; if (bus.rdata !== exp_rdata) begin errors++; $display("FAIL rand_rdata n=%0d addr=%h got=%h exp=%h", n, a, bus.rdata, exp_rdata); end
         checks++; if (gpio_out !== m_gpio) begin errors++; $display("FAIL rand_gpio n=%0d got=%h exp=%h", n, gpio_out, m_gpio); end
         checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err n=%0d got=%b exp=%b", n, err, m_err); end
      end
   endtask

   task automatic test_reset_mid();
      cycle(32'h10, 32'h0BAD_F00D, 4'hF);
      cycle(A_GPIO, 32'hFF, 4'hF);
      cycle(A_BAD, '0, 4'h1);
      cycle(A_GPIO, '0, 4'h0);
      checks++; if (bus.rdata !== 32'hFF || err !== 1'b1) begin errors++; $display("FAIL pre_reset_state rdata=%h err=%b exp=%h/1", bus.rdata, err, 32'hFF); end
      #2 rst = 1'b1;
      #1;
      checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL async_gpio got=%h exp=%h", gpio_out, 32'h0); end
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL async_rdata got=%h exp=%h", bus.rdata, 32'h0); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL async_err got=%b exp=0", err); end
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      cycle(A_LO, '0, 4'h0);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL post_reset_lo got=%h exp=%h", bus.rdata, 32'h0); end
      cycle(32'h10, '0, 4'h0);
      checks++; if (bus.rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL ram_survives_reset got=%h exp=%h", bus.rdata, 32'h0BAD_F00D); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_byte_write();
      test_read_first();
      test_gpio();
      test_counter();
      test_error();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024 (power of two, at most 65536), giving the RAM depth in 32-bit words at byte addresses 0 to DEPTH_WORDS*4-1.
REQ-002 The block SHALL have parameter MMIO_BASE, default 32'hFFFF_FF00, giving the base of a 16-byte MMIO window.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port addr, input, 32 bits: byte address from the core ALU; addr[1:0] is ignored for word selection.
REQ-006 Port wdata, input, 32 bits: lane-aligned store data.
REQ-007 Port we, input, 4 bits: byte-lane write enables; we[i] writes wdata[8i+7:8i].
REQ-008 Port rdata, input-side data to the core, output, 32 bits: registered full word read from the previous cycle's addr.
REQ-009 Port gpio_out, output, 32 bits: the MMIO GPIO register.
REQ-010 Port err, output, 1 bit: sticky access-error flag.

Function
REQ-011 Every cycle, the block SHALL capture in rdata, at the clock edge, the word selected by addr. Read latency is exactly 1 cycle, with no read enable.
REQ-012 RAM region (addr < DEPTH_WORDS*4): index = addr[31:2]; each lane with a set we bit is written at the edge; other lanes are unchanged.
REQ-013 Read and write to the same word in one cycle SHALL be read-first: rdata gets the pre-write word, and the new data is visible on the next read.
REQ-014 MMIO offset 0x0 (GPIO) SHALL be read/write with byte enables honoured; gpio_out reflects the register directly.
REQ-015 MMIO offset 0x4 (CYCLE_LO) SHALL be read-only and return counter bits [31:0].
REQ-016 A read of CYCLE_LO SHALL, at the same edge, snapshot counter bits [63:32] into hi_snap.
REQ-017 MMIO offset 0x8 (CYCLE_HI) SHALL be read-only and return hi_snap.
REQ-018 MMIO offset 0xC (STATUS) SHALL read as {31'b0, err}.
REQ-019 A write to STATUS with we[0]=1 and wdata[0]=1 SHALL clear err.
REQ-020 Writes with any we bit set to read-only MMIO offsets SHALL be ignored and SHALL set err.
REQ-021 The cycle counter SHALL be 64 bits, increment by 1 every cycle out of reset, and wrap from all-ones to 0 with no flag.
REQ-022 An unmapped address (neither RAM nor the MMIO window) SHALL read as 32'h0; a write (any we bit) to it SHALL be discarded and SHALL set err.
REQ-023 A read-only unmapped access SHALL NOT set err.
REQ-024 When an err clear and an err set occur in the same cycle, set SHALL win.
REQ-025 MMIO reads SHALL have the same 1-cycle latency as RAM reads, and the MMIO value SHALL be sampled at the addressing edge.
REQ-026 A we value of 4'b0000 SHALL NOT modify any state other than rdata, hi_snap and the counter.

Reset
REQ-027 While rst=1: rdata=0, gpio_out=0, err=0, counter=0 and hi_snap=0, applied asynchronously.
REQ-028 RAM contents SHALL NOT be cleared by reset; they are undefined until written.
REQ-029 Release of rst SHALL take effect at the first rising clk edge after deassertion; the counter reads 0 in the first post-reset read of CYCLE_LO issued at that edge.
REQ-030 Assertion of rst in the same cycle as a write SHALL discard the write to MMIO registers; the RAM write MAY complete.

Verification
REQ-031 Byte write: write 32'hAABBCCDD to addr 0x10 with we=4'hF, then write 32'h11223344 to 0x10 with we=4'b0101, then read 0x10 -> rdata=32'hAA22CC44 one cycle after the read.
REQ-032 Read-first: in one cycle read and write 0x20 with wdata=32'h5 (old value 32'h9) -> rdata=32'h9; the next read of 0x20 gives 32'h5.
REQ-033 Counter coherence: force the counter to 64'h0000_0001_FFFF_FFFF, read CYCLE_LO, then CYCLE_HI -> 32'hFFFF_FFFF then 32'h1, even though the counter has advanced; a counter of all-ones wraps to 0.
REQ-034 Error path: write to addr 0x8000_0000 (above RAM) with we=4'h1 -> err=1, and the next read returns 0.
REQ-035 Error path, clear: write 1 to STATUS -> err=0; a simultaneous clear and new bad write -> err stays 1.
REQ-036 Reset mid-operation: with gpio_out=32'hFF, assert rst between clock edges -> gpio_out=0, rdata=0 and err=0 immediately, without waiting for a clock edge.
